// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Holds the FSM state encoding, the op codes and the iteration-counter width helper.
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        DFIX,
        DONE
    } state_e;

    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/multdiv_seq_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and conditionally subtracts the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // The remainder stays below the divisor magnitude (at most 2^(WIDTH-1)),
    // so one extra bit is enough to see the borrow.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign fits    = ~diff[WIDTH];

    assign rem_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer
// delivering a 2*WIDTH result into the HI/LO pair through a start/done handshake.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hi_write,
    output logic             lo_write
);

    import multdiv_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mul_q, mul_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_q_q, sign_q_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] step_rem, step_quo;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // The accumulator carries one guard bit so that negating INT_MIN cannot overflow.
    assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        case ({mul_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mul_d    = mul_q;
        qm1_d    = qm1_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sign_a_d = sign_a_q;
        sign_q_d = sign_q_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        div_zero = done & dz_q;
        hi_write = done & ~dz_q;
        lo_write = done & ~dz_q;

        case (state_q)
            IDLE: begin
                if (start && (op == OP_MULT || op == OP_DIV)) begin
                    count_d = CW'(WIDTH);
                    dz_d    = 1'b0;
                    if (op == OP_MULT) begin
                        mcand_d = a;
                        mul_d   = b;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        state_d = MULT;
                    end else if (b == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        sign_a_d = a[WIDTH-1];
                        sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                        quo_d    = a[WIDTH-1] ? -a : a;
                        dvsr_d   = b[WIDTH-1] ? -b : b;
                        rem_d    = '0;
                        state_d  = DIV;
                    end
                end
            end
            MULT: begin
                acc_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                mul_d   = {booth_sum[0], mul_q[WIDTH-1:1]};
                qm1_d   = mul_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    hi_d    = booth_sum[WIDTH:1];
                    lo_d    = {booth_sum[0], mul_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DIV: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DFIX;
                end
            end
            DFIX: begin
                lo_d    = sign_q_q ? -quo_q : quo_q;
                hi_d    = sign_a_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mul_q    <= '0;
            qm1_q    <= 1'b0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sign_a_q <= 1'b0;
            sign_q_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mul_q    <= mul_d;
            qm1_q    <= qm1_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sign_a_q <= sign_a_d;
            sign_q_q <= sign_q_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: stimulus pushes expected HI/LO/flags/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_multdiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero, hi_write, lo_write;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];

    multdiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .hi_write (hi_write),
        .lo_write (lo_write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_flags"}, {61'd0, div_zero, hi_write, lo_write},
                      {61'd0, e.dz, ~e.dz, ~e.dz});
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    // Cycle 1 is the period right after the start edge; done due in cycle lat.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (push) begin
            e.name = name;
            e.hi   = ehi;
            e.lo   = elo;
            e.dz   = edz;
            e.due  = cyc + lat - 1;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, {62'd0, sb.size() != 0, busy}, 64'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {59'd0, busy, done, div_zero, hi_write, lo_write}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;

        // MULT 7 * -3, with busy window tracked
        issue("mul_7_m3", 2'b01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
        bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (busy !== (k <= 33)) bad++;
        end
        check("mul_busy_window", 64'(bad), 64'd0);
        drain("mul_7_m3");

        issue("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
        drain("div_m7_2");

        issue("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
        drain("div_7_m2");

        issue("mul_m4_m5", 2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd0, 32'd20, 1'b0, 33, 1'b1);
        drain("mul_m4_m5");

        // 0x451 / 0x20 leaves hi=0x11, lo=0x22 ahead of the divide-by-zero
        issue("div_prep", 2'b10, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34, 1'b1);
        drain("div_prep");
        issue("div_zero", 2'b10, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1, 1, 1'b1);
        drain("div_zero");

        issue("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, 1'b1);
        drain("div_min_m1");

        issue("mul_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 33, 1'b1);
        drain("mul_min_min");

        // Invalid op must not start anything
        issue("nop", 2'b11, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1, 1'b0);
        check("nop_idle", {63'd0, busy}, 64'd0);

        // Start while busy is ignored, not queued
        issue("mul_5_6", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("mul_5_6");
        repeat (40) @(negedge clk);
        check("ignored_start_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a divide aborts it without a done pulse
        issue("div_abort", 2'b10, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 34, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ctrl", {59'd0, busy, done, div_zero, hi_write, lo_write}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue("mul_3_4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 1'b1);
        drain("mul_3_4");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
Iterative signed multiply/divide sequencer for the multicycle MIPS core. It accepts one operation from the control FSM through a start/done handshake. It runs radix-2 Booth multiplication or restoring division over WIDTH iterations and delivers a 64-bit result into the HI/LO register pair. It flags divide-by-zero so the control unit can branch to the exception handler.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH wide (HI = upper or remainder, LO = lower or quotient)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets the block)
start  in  1  one-cycle request; sampled only in IDLE
op  in  2  01 = MULT (signed), 10 = DIV (signed), 00/11 = no-op (start ignored)
a  in  WIDTH  operand A (rs contents); multiplicand or dividend
b  in  WIDTH  operand B (rt contents); multiplier or divisor
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; the operation is finished
div_zero  out  1  high with done when DIV had b == 0
hi  out  WIDTH  registered HI result, held until the next write
lo  out  WIDTH  registered LO result, held until the next write
hi_write  out  1  write enable for the HI register, coincident with done
lo_write  out  1  write enable for the LO register, coincident with done

Behaviour:
- Reset (async, reset=0): state=IDLE; busy, done, div_zero, hi_write and lo_write are 0; hi, lo and all internal registers are 0. A reset mid-operation aborts the operation and produces no done pulse.
- States: IDLE, MULT, DIV, DFIX, DONE.
- IDLE: on an edge with start=1 and op valid, the block latches a and b and sets count=WIDTH.
  - op=MULT goes to MULT.
  - op=DIV with b!=0 goes to DIV, with operands converted to magnitudes and the sign bits saved.
  - op=DIV with b==0 goes directly to DONE with div_zero=1.
  - An invalid op or start=0 stays in IDLE.
- MULT: one Booth step per edge on the {acc, mult, q-1} register, using an arithmetic right shift and decrementing count. After the WIDTH-th step the block goes to DONE with {hi, lo} = signed product.
- DIV: one restoring step per edge on the remainder/quotient pair, decrementing count. After the WIDTH-th step the block goes to DFIX.
- DFIX: one cycle of sign correction.
  - Quotient is negated if sign(a) XOR sign(b).
  - Remainder takes the sign of a.
  - lo = quotient, hi = remainder; then go to DONE.
- DONE: exactly one cycle, then IDLE.
  - done=1.
  - hi_write=lo_write=1, except on divide-by-zero, where both are 0 and hi/lo are left unchanged.
- Latency, measured in cycles after the start edge:
  - MULT: done is high in cycle WIDTH+1.
  - DIV: done is high in cycle WIDTH+2.
  - Divide-by-zero: done is high in cycle 1.
- start during busy (including DONE) is ignored and not queued. a and b may change freely after the start edge.
- Arithmetic is two's complement. INT_MIN/-1 gives lo=0x80000000 and hi=0 (wrap, no trap). INT_MIN*INT_MIN gives 0x4000000000000000.
- div_zero is cleared on the next accepted start. It is a pulse aligned with done, not sticky.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE, MULT, DIV, DFIX, DONE);
  - op encodings OP_MULT=2'b01 and OP_DIV=2'b10;
  - the iteration-count width constant, clog2(WIDTH+1).
- One sub-module, div_step: a combinational restoring-division iteration, with inputs rem and quotient and outputs next rem and next quotient. It is instantiated once inside multdiv_seq.
- The Booth step stays inline.

Test Plan:
- MULT a=7, b=-3 (0xFFFFFFFD): hi=0xFFFFFFFF, lo=0xFFFFFFEB; done, hi_write and lo_write high exactly 33 cycles after start; busy high for cycles 1..33.
- DIV a=-7, b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); done at cycle 34, div_zero=0.
- DIV a=100, b=0 (with prior hi=0x11, lo=0x22): done and div_zero high at cycle 1; hi_write=lo_write=0; hi/lo remain 0x11/0x22.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - MULT 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0.
- Start MULT 5*6, pulse start with op=DIV at cycle 10: the second request is ignored; a single done at cycle 33 with lo=30, hi=0.
- Start DIV, assert reset=0 at cycle 15 for 2 cycles: all outputs are 0 immediately with no done pulse. A fresh MULT 3*4 after release gives lo=12 at cycle 33.
